// File: rtl/riscv_pipe_pkg.sv
// Shared widths, constants and payload types for the fetch/decode pipeline slice.
package riscv_pipe_pkg;

  localparam int unsigned XLEN          = 32;
  localparam int unsigned IMM_FIELD_MSB = 31;
  localparam int unsigned IMM_FIELD_LSB = 7;
  localparam int unsigned IMM_W         = IMM_FIELD_MSB - IMM_FIELD_LSB + 1;

  localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_pkt_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            valid;
  } if_id_t;

  // Sequential PC increment; wraps silently at 2^32.
  function automatic logic [XLEN-1:0] pc_inc4(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding slot for the fetch packet whose memory data would be lost
// once the instruction memory is re-addressed during a decode stall.
module fetch_skid_buffer
  import riscv_pipe_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       capture_i,
  input  logic       consume_i,
  input  logic       squash_i,
  input  fetch_pkt_t data_i,
  output fetch_pkt_t data_o,
  output logic       valid_o
);

  logic       valid_q, valid_d;
  fetch_pkt_t data_q, data_d;

  // Squash and consume both empty the slot; capture only fills an empty one.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (squash_i || consume_i) begin
      valid_d = 1'b0;
    end else if (capture_i && !valid_q) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_decode_stage.sv
// Instruction fetch (PC, in-flight tracking, skid slot) plus the IF/ID register
// that feeds decode and its immediate extender.
module fetch_decode_stage
  import riscv_pipe_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = riscv_pipe_pkg::RESET_PC,
  parameter logic [XLEN-1:0] NOP_INSTR = riscv_pipe_pkg::NOP_INSTR
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_f,
  input  logic             stall_d,
  input  logic             flush_d,
  input  logic             pc_src_e,
  input  logic [XLEN-1:0]  pc_target_e,
  output logic [XLEN-1:0]  imem_addr,
  input  logic [XLEN-1:0]  imem_rdata,
  output logic [XLEN-1:0]  instr_d,
  output logic [IMM_W-1:0] imm_input_d,
  output logic [XLEN-1:0]  pc_d,
  output logic [XLEN-1:0]  pc_plus4_d,
  output logic             valid_d
);

  logic [XLEN-1:0] pc_f_q, pc_f_d;
  logic [XLEN-1:0] pc_f2_q, pc_f2_d;
  logic            valid_f2_q, valid_f2_d;
  if_id_t          if_id_q, if_id_d;

  fetch_pkt_t f2_pkt, skid_pkt, ld_pkt;
  logic       skid_valid, skid_capture, skid_consume, ld_valid;

  // Redirect beats stall; the in-flight fetch is squashed on redirect.
  always_comb begin
    pc_f_d     = pc_f_q;
    pc_f2_d    = pc_f2_q;
    valid_f2_d = valid_f2_q;
    if (pc_src_e) begin
      pc_f_d     = pc_target_e & ~XLEN'(3);
      valid_f2_d = 1'b0;
    end else if (!stall_f) begin
      pc_f_d     = pc_inc4(pc_f_q);
      pc_f2_d    = pc_f_q;
      valid_f2_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_f_q     <= RESET_PC;
      pc_f2_q    <= RESET_PC;
      valid_f2_q <= 1'b0;
    end else begin
      pc_f_q     <= pc_f_d;
      pc_f2_q    <= pc_f2_d;
      valid_f2_q <= valid_f2_d;
    end
  end

  always_comb begin
    f2_pkt.instr = imem_rdata;
    f2_pkt.pc    = pc_f2_q;
  end

  assign skid_capture = stall_d && valid_f2_q && !skid_valid;
  assign skid_consume = !stall_d && !flush_d;

  fetch_skid_buffer u_skid (
    .clk       (clk),
    .rst       (rst),
    .capture_i (skid_capture),
    .consume_i (skid_consume),
    .squash_i  (pc_src_e),
    .data_i    (f2_pkt),
    .data_o    (skid_pkt),
    .valid_o   (skid_valid)
  );

  assign ld_pkt   = skid_valid ? skid_pkt : f2_pkt;
  assign ld_valid = skid_valid || valid_f2_q;

  // Flush keeps pc_d/pc_plus4_d; an invalid load still writes a clean NOP.
  always_comb begin
    if_id_d = if_id_q;
    if (flush_d) begin
      if_id_d.instr = NOP_INSTR;
      if_id_d.valid = 1'b0;
    end else if (!stall_d) begin
      if_id_d.instr    = ld_valid ? ld_pkt.instr : NOP_INSTR;
      if_id_d.pc       = ld_pkt.pc;
      if_id_d.pc_plus4 = pc_inc4(ld_pkt.pc);
      if_id_d.valid    = ld_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      if_id_q.instr    <= NOP_INSTR;
      if_id_q.pc       <= '0;
      if_id_q.pc_plus4 <= '0;
      if_id_q.valid    <= 1'b0;
    end else begin
      if_id_q <= if_id_d;
    end
  end

  assign imem_addr   = pc_f_q;
  assign instr_d     = if_id_q.instr;
  assign pc_d        = if_id_q.pc;
  assign pc_plus4_d  = if_id_q.pc_plus4;
  assign valid_d     = if_id_q.valid;
  assign imm_input_d = if_id_q.instr[IMM_FIELD_MSB:IMM_FIELD_LSB];

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Directed bench for fetch_decode_stage: a synchronous imem returning addr^KEY,
// hazard sequences driven by hand, expected values written out per step.
module tb_fetch_decode_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst, stall_f, stall_d, flush_d, pc_src_e;
  logic [31:0] pc_target_e, imem_addr, imem_rdata;
  logic [31:0] instr_d, pc_d, pc_plus4_d;
  logic [24:0] imm_input_d;
  logic        valid_d;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Synchronous instruction memory: address in cycle n, data in cycle n+1.
  always @(posedge clk) imem_rdata <= imem_addr ^ KEY;

  fetch_decode_stage dut (
    .clk         (clk),
    .rst         (rst),
    .stall_f     (stall_f),
    .stall_d     (stall_d),
    .flush_d     (flush_d),
    .pc_src_e    (pc_src_e),
    .pc_target_e (pc_target_e),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .instr_d     (instr_d),
    .imm_input_d (imm_input_d),
    .pc_d        (pc_d),
    .pc_plus4_d  (pc_plus4_d),
    .valid_d     (valid_d)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_valid(input string tag, input logic [31:0] pc);
    logic [31:0] ins;
    ins = pc ^ KEY;
    check_eq({tag, ".valid"}, 32'(valid_d), 32'd1);
    check_eq({tag, ".pc"}, pc_d, pc);
    check_eq({tag, ".instr"}, instr_d, ins);
    check_eq({tag, ".pc4"}, pc_plus4_d, pc + 32'd4);
    check_eq({tag, ".imm"}, 32'(imm_input_d), ins >> 7);
  endtask

  task automatic chk_bubble(input string tag);
    check_eq({tag, ".valid"}, 32'(valid_d), 32'd0);
    check_eq({tag, ".instr"}, instr_d, NOP);
  endtask

  task automatic set_hz(input logic sf, input logic sd, input logic fl,
                        input logic br, input logic [31:0] tgt);
    stall_f     = sf;
    stall_d     = sd;
    flush_d     = fl;
    pc_src_e    = br;
    pc_target_e = tgt;
  endtask

  initial begin
    rst = 1'b1;
    set_hz(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    chk_bubble("rst");
    check_eq("rst.pc", pc_d, 32'h0);
    check_eq("rst.pc4", pc_plus4_d, 32'h0);
    check_eq("rst.addr", imem_addr, 32'h0);
    check_eq("rst.imm", 32'(imm_input_d), NOP >> 7);

    // Plain run: pc_d = 0,4,8 from the 2nd edge after reset.
    rst = 1'b0;
    tick();
    chk_bubble("t1.e1");
    check_eq("t1.e1.addr", imem_addr, 32'h4);
    tick();
    chk_valid("t1.e2", 32'h0);
    tick();
    chk_valid("t1.e3", 32'h4);
    tick();
    chk_valid("t1.e4", 32'h8);

    // Three-cycle stall holding pc_d=8; the skid supplies 12 afterwards.
    set_hz(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_valid("t2.hold", 32'h8);
      check_eq("t2.addr", imem_addr, 32'h10);
    end
    set_hz(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    chk_valid("t2.skid", 32'hC);

    // Redirect at pc_f=20 to 0x100 with flush: two bubbles, then target.
    check_eq("t3.pre.addr", imem_addr, 32'h14);
    set_hz(1'b0, 1'b0, 1'b1, 1'b1, 32'h100);
    tick();
    chk_bubble("t3.b1");
    check_eq("t3.addr", imem_addr, 32'h100);
    set_hz(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    chk_bubble("t3.b2");
    tick();
    chk_valid("t3.tgt", 32'h100);
    tick();
    chk_valid("t3.tgt4", 32'h104);

    // Redirect during a stall with a full skid: redirect wins, skid dropped.
    set_hz(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    chk_valid("t4.hold1", 32'h104);
    tick();
    chk_valid("t4.hold2", 32'h104);
    set_hz(1'b1, 1'b1, 1'b1, 1'b1, 32'h203);
    tick();
    check_eq("t4.addr", imem_addr, 32'h200);
    chk_bubble("t4.b1");
    set_hz(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    chk_bubble("t4.skid_clr");
    tick();
    chk_valid("t4.tgt", 32'h200);
    tick();
    chk_valid("t4.tgt4", 32'h204);

    // Reset pulsed mid-stall with the skid full.
    set_hz(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    chk_valid("t5.hold", 32'h204);
    rst = 1'b1;
    tick();
    chk_bubble("t5.rst");
    check_eq("t5.addr", imem_addr, 32'h0);
    check_eq("t5.pc", pc_d, 32'h0);
    rst = 1'b0;
    set_hz(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    chk_bubble("t5.e1");
    check_eq("t5.e1.addr", imem_addr, 32'h4);
    tick();
    chk_valid("t5.e2", 32'h0);
    tick();
    chk_valid("t5.e3", 32'h4);

    // PC wrap from 0xFFFF_FFFC to 0.
    set_hz(1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
    tick();
    check_eq("t6.addr_top", imem_addr, 32'hFFFF_FFFC);
    chk_bubble("t6.b1");
    set_hz(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    check_eq("t6.addr_wrap", imem_addr, 32'h0);
    chk_bubble("t6.b2");
    tick();
    chk_valid("t6.top", 32'hFFFF_FFFC);
    check_eq("t6.pc4_zero", pc_plus4_d, 32'h0);
    tick();
    chk_valid("t6.after", 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
